lockin_cordic_polar: RTL and testbench

- Downstream of the lock-in amplifier stage. Consumes each filtered in-phase/quadrature sample pair (x, y) on that stage's done strobe.
- Converts the pair to magnitude and phase with an iterative vectoring-mode CORDIC, one micro-rotation per clock.
- Results feed the metrology/telemetry path as amplitude and phase of the modulated signal.

---
 rtl/lockin_cordic_polar.sv | 195 +++++++++++++++++++
 tb/tb_lockin_cordic_polar.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lockin_cordic_polar.sv
// Rectangular-to-polar converter for lock-in I/Q pairs using an iterative vectoring CORDIC.
// Optional gain compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module lockin_cordic_polar #(
  parameter int unsigned NUM_BITS = 24,
  parameter int unsigned NUM_ITER = 20
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic signed [NUM_BITS-1:0] x_i,
  input  logic signed [NUM_BITS-1:0] y_i,
  output logic        [NUM_BITS:0]   mag_o,
  output logic signed [NUM_BITS-1:0] phase_o,
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam int unsigned XW = NUM_BITS + 3;
  localparam int unsigned ZW = NUM_BITS + 1;
  localparam int unsigned CW = $clog2(NUM_ITER);
  localparam int unsigned FB = 62;

  typedef logic [NUM_ITER-1:0][ZW-1:0] atan_tab_t;

  // atan(1/m) in 2^-FB fixed point via the alternating Taylor series
  function automatic logic [127:0] atan_inv(input logic [127:0] m);
    logic [127:0] p;
    logic [127:0] sum;
    logic [127:0] k;
    p   = (128'd1 << FB) / m;
    sum = '0;
    k   = '0;
    while (p != 0) begin
      if (k[0]) sum = sum - p / (128'd2 * k + 128'd1);
      else      sum = sum + p / (128'd2 * k + 128'd1);
      p = p / (m * m);
      k = k + 128'd1;
    end
    return sum;
  endfunction

  // Angle table scaled so that pi == 2^(NUM_BITS-1); pi itself from Machin's formula
  function automatic atan_tab_t build_atan_tab();
    logic [127:0] pi_fix;
    logic [127:0] a;
    atan_tab_t    tab;
    pi_fix = 128'd16 * atan_inv(128'd5) - 128'd4 * atan_inv(128'd239);
    tab    = '0;
    tab[0] = ZW'(1) << (NUM_BITS - 3);
    for (int i = 1; i < int'(NUM_ITER); i++) begin
      a = atan_inv(128'd1 << i);
      tab[CW'(i)] = ZW'(((a << (NUM_BITS - 1)) + (pi_fix >> 1)) / pi_fix);
    end
    return tab;
  endfunction

  localparam atan_tab_t ATAN_TAB = build_atan_tab();

  typedef enum logic [2:0] {IDLE, PREROT, ITER, SCALE, OUT} state_t;

  state_t                   state_q, state_n;
  logic signed [XW-1:0]     x_q, x_n, y_q, y_n, xs, ys;
  logic signed [ZW-1:0]     z_q, z_n;
  logic        [CW-1:0]     iter_q, iter_n;
  logic                     zero_q, zero_n;
  logic        [NUM_BITS:0] mag_n;
  logic signed [NUM_BITS-1:0] phase_n;
  logic                     valid_n, busy_n, overrun_n;

`ifdef CORDIC_GAIN_COMP_EN
  localparam longint unsigned K_SCALED =
    (64'd6072529350 * (64'd1 << NUM_BITS) + 64'd5000000000) / 64'd10000000000;
  localparam logic [NUM_BITS-1:0] K_GAIN = NUM_BITS'(K_SCALED);
  localparam int unsigned PW = XW + NUM_BITS + 1;
  logic signed [PW-1:0] prod;
  assign prod = PW'(x_q) * PW'($signed({1'b0, K_GAIN}));
`endif

  // State, datapath and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= '0;
      zero_q    <= 1'b0;
      mag_o     <= '0;
      phase_o   <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      state_q   <= state_n;
      x_q       <= x_n;
      y_q       <= y_n;
      z_q       <= z_n;
      iter_q    <= iter_n;
      zero_q    <= zero_n;
      mag_o     <= mag_n;
      phase_o   <= phase_n;
      valid_o   <= valid_n;
      busy_o    <= busy_n;
      overrun_o <= overrun_n;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_n   = state_q;
    x_n       = x_q;
    y_n       = y_q;
    z_n       = z_q;
    iter_n    = iter_q;
    zero_n    = zero_q;
    mag_n     = mag_o;
    phase_n   = phase_o;
    valid_n   = 1'b0;
    busy_n    = busy_o;
    overrun_n = overrun_o;
    xs        = x_q >>> iter_q;
    ys        = y_q >>> iter_q;

    if (valid_i && (state_q != IDLE)) overrun_n = 1'b1;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          x_n     = XW'(x_i);
          y_n     = XW'(y_i);
          zero_n  = (x_i == '0) && (y_i == '0);
          iter_n  = '0;
          busy_n  = 1'b1;
          state_n = PREROT;
        end
      end
      PREROT: begin
        // Fold the left half-plane into the CORDIC convergence range
        if (x_q[XW-1]) begin
          if (!y_q[XW-1]) begin
            x_n = y_q;
            y_n = -x_q;
            z_n = ZW'(1) << (NUM_BITS - 2);
          end else begin
            x_n = -y_q;
            y_n = x_q;
            z_n = -(ZW'(1) << (NUM_BITS - 2));
          end
        end else begin
          z_n = '0;
        end
        state_n = ITER;
      end
      ITER: begin
        if (!y_q[XW-1]) begin
          x_n = x_q + ys;
          y_n = y_q - xs;
          z_n = z_q + $signed(ATAN_TAB[iter_q]);
        end else begin
          x_n = x_q - ys;
          y_n = y_q + xs;
          z_n = z_q - $signed(ATAN_TAB[iter_q]);
        end
        if (iter_q == CW'(NUM_ITER - 1)) begin
          iter_n = '0;
`ifdef CORDIC_GAIN_COMP_EN
          state_n = SCALE;
`else
          state_n = OUT;
`endif
        end else begin
          iter_n = iter_q + CW'(1);
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      SCALE: begin
        x_n     = XW'(prod >>> NUM_BITS);
        state_n = OUT;
      end
`endif
      OUT: begin
        if (zero_q || x_q[XW-1])           mag_n = '0;
        else if (|x_q[XW-2:NUM_BITS+1])    mag_n = '1;
        else                               mag_n = x_q[NUM_BITS:0];
        phase_n = zero_q ? '0 : z_q[NUM_BITS-1:0];
        valid_n = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lockin_cordic_polar.sv
// Self-checking bench for lockin_cordic_polar against a real-arithmetic polar model.
// Expectations follow CORDIC_GAIN_COMP_EN when the bench is built with that macro.
module tb_lockin_cordic_polar;

  localparam int unsigned NB = 24;
  localparam int unsigned NI = 20;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = NI + 3;
`else
  localparam int LAT = NI + 2;
`endif
  localparam int  MAG_TOL = NI + 4;
  localparam real PI = 3.14159265358979323846;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              valid_i;
  logic [NB-1:0]     x_i, y_i;
  logic [NB:0]       mag_o;
  logic signed [NB-1:0] phase_o;
  logic              valid_o, busy_o, overrun_o;

  int  checks = 0;
  int  errors = 0;
  real gain_n;

  lockin_cordic_polar #(.NUM_BITS(NB), .NUM_ITER(NI)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .x_i(x_i), .y_i(y_i),
    .mag_o(mag_o), .phase_o(phase_o), .valid_o(valid_o), .busy_o(busy_o),
    .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Difference on the phase circle, folded into [-2^(NB-1), 2^(NB-1))
  function automatic int wrap(input int d);
    int m;
    m = d & 32'h00FF_FFFF;
    if (m >= 8388608) m = m - 16777216;
    return m;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol,
                         input bit circ);
    int  d;
    bit  ok;
    d  = circ ? wrap(obs - exp) : obs - exp;
    ok = (d <= tol) && (d >= -tol);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  // Compare outputs with the ideal polar form of (x, y)
  task automatic check_result(input string tag, input int x, input int y);
    real r, em, ep, tp;
    if (x == 0 && y == 0) begin
      chk({tag, "_mag"}, int'(mag_o), 0);
      chk({tag, "_phase"}, int'(phase_o), 0);
      return;
    end
    r = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
`ifdef CORDIC_GAIN_COMP_EN
    em = r;
`else
    em = r * gain_n;
`endif
    ep = $atan2(real'(y), real'(x)) / PI * 8388608.0;
    tp = 6.0 + real'(NI) * 8388608.0 / (PI * gain_n * r);
    chk_tol({tag, "_mag"}, int'(mag_o), rnd(em), MAG_TOL, 1'b0);
    chk_tol({tag, "_phase"}, int'(phase_o), rnd(ep), rnd(tp), 1'b1);
  endtask

  task automatic pulse(input int x, input int y);
    x_i     = NB'(x);
    y_i     = NB'(y);
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_i);
      #1;
      if (valid_o) n++;
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic convert(input string tag, input int x, input int y);
    int lat;
    pulse(x, y);
    wait_valid(LAT + 20, lat);
    chk({tag, "_lat"}, lat, LAT);
    check_result(tag, x, y);
  endtask

  int dx[8] = '{0, 0, -1000000, -1000000, -8388608, 0, 8388607, -8388608};
  int dy[8] = '{1000000, -1000000, 0, -1, -8388608, 0, 8388607, 8388607};

  initial begin
    int lat, n, rx, ry;
    real t;
    gain_n = 1.0;
    t = 1.0;
    for (int i = 0; i < int'(NI); i++) begin
      gain_n = gain_n * $sqrt(1.0 + t);
      t = t / 4.0;
    end

    reset_i = 1'b1;
    valid_i = 1'b0;
    x_i = '0;
    y_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_mag", int'(mag_o), 0);
    chk("rst_phase", int'(phase_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Positive real axis: latency, busy framing, single-cycle strobe, hold
    pulse(1000000, 0);
    chk("busy_rise", int'(busy_o), 1);
    wait_valid(LAT + 20, lat);
    chk("lat_first", lat, LAT);
    chk("busy_fall", int'(busy_o), 0);
    check_result("xpos", 1000000, 0);
    @(posedge clk_i);
    #1;
    chk("valid_one_cycle", int'(valid_o), 0);
    check_result("xpos_hold", 1000000, 0);

    for (int k = 0; k < 8; k++) convert($sformatf("dir%0d", k), dx[k], dy[k]);
    chk("no_overrun_spaced", int'(overrun_o), 0);

    // Second strobe five cycles into a conversion is dropped
    pulse(3000000, 2000000);
    repeat (4) @(posedge clk_i);
    #1;
    chk("overrun_before", int'(overrun_o), 0);
    pulse(-500000, 700000);
    chk("overrun_set", int'(overrun_o), 1);
    wait_valid(LAT + 20, lat);
    chk("overrun_lat", lat, LAT - 5);
    check_result("overrun_res", 3000000, 2000000);
    count_valid(LAT + 10, n);
    chk("overrun_no_second", n, 0);
    chk("overrun_sticky", int'(overrun_o), 1);

    // Strobe coinciding with the output cycle is dropped
    do_reset();
    chk("overrun_cleared", int'(overrun_o), 0);
    pulse(-2000000, 4000000);
    repeat (LAT - 1) @(posedge clk_i);
    #1;
    pulse(123456, -654321);
    chk("outcyc_valid", int'(valid_o), 1);
    check_result("outcyc_res", -2000000, 4000000);
    chk("outcyc_overrun", int'(overrun_o), 1);
    count_valid(LAT + 10, n);
    chk("outcyc_no_second", n, 0);

    // Minimum strobe period back to back
    do_reset();
    pulse(5000000, -3000000);
    wait_valid(LAT + 20, lat);
    chk("minper_lat0", lat, LAT);
    check_result("minper_res0", 5000000, -3000000);
    convert("minper1", -6000000, -1000000);
    chk("minper_overrun", int'(overrun_o), 0);

    // Reset in the middle of a conversion
    pulse(2500000, 2500000);
    repeat (9) @(posedge clk_i);
    #1;
    chk("mid_busy", int'(busy_o), 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("midrst_mag", int'(mag_o), 0);
    chk("midrst_phase", int'(phase_o), 0);
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_overrun", int'(overrun_o), 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    count_valid(LAT + 20, n);
    chk("midrst_no_valid", n, 0);
    convert("after_rst", -3000000, 1500000);

    for (int k = 0; k < 10; k++) begin
      rx = int'($urandom) >>> 8;
      ry = int'($urandom) >>> 8;
      convert($sformatf("rand%0d", k), rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
